// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with stall, flush, sticky signed overflow and halt drain FSM
module ex_mem_reg #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ex_valid,
  input  logic [N-1:0] ex_alu_out,
  input  logic         ex_zero,
  input  logic         ex_ofl,
  input  logic         ex_sign,
  input  logic [N-1:0] ex_st_data,
  input  logic [2:0]   ex_rd,
  input  logic [2:0]   ex_ctl,
  input  logic         ex_halt,
  input  logic         mem_stall,
  input  logic         flush,
  output logic         ex_ready,
  output logic         mem_valid,
  output logic [N-1:0] mem_alu_out,
  output logic [N-1:0] mem_st_data,
  output logic         mem_zero,
  output logic [2:0]   mem_rd,
  output logic [2:0]   mem_ctl,
  output logic         ofl_err,
  output logic         halted
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, state_d;
  logic take, drain_done;
  assign ex_ready   = (state == RUN) & ~mem_stall;
  assign take       = ex_valid & ~flush;
  assign drain_done = (state == DRAIN) & ~mem_stall;
  assign halted     = (state == HALTED);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_d;
  always_comb begin
    state_d = (ex_ready & take & ex_halt) ? DRAIN : drain_done ? HALTED : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_valid   <= 1'b0;
      mem_alu_out <= '0;
      mem_st_data <= '0;
      mem_zero    <= 1'b0;
      mem_rd      <= 3'b000;
      mem_ctl     <= 3'b000;
      ofl_err     <= 1'b0;
    end else if (ex_ready) begin
      mem_valid   <= take;
      mem_alu_out <= ex_alu_out;
      mem_st_data <= ex_st_data;
      mem_zero    <= ex_zero;
      mem_rd      <= ex_rd;
      mem_ctl     <= take ? ex_ctl : 3'b000;
      ofl_err     <= ofl_err | (take & ex_sign & ex_ofl);
    end else if (drain_done) begin
      mem_valid   <= 1'b0;
    end
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: table-driven vectors fed through an expectation queue against ex_mem_reg
module tb_ex_mem_reg;
  logic clk = 0, rst_n = 1;
  logic ex_valid, ex_zero, ex_ofl, ex_sign, ex_halt, mem_stall, flush;
  logic [15:0] ex_alu_out, ex_st_data;
  logic [2:0] ex_rd, ex_ctl;
  logic ex_ready, mem_valid, mem_zero, ofl_err, halted;
  logic [15:0] mem_alu_out, mem_st_data;
  logic [2:0] mem_rd, mem_ctl;
  int checks = 0, errors = 0;

  typedef struct {
    logic stall, flush, valid, sign, ofl, halt, zero;
    logic [2:0] rd, ctl;
    logic [15:0] alu;
    logic e_ready, e_valid, e_zero, e_ofl, e_halted;
    logic [2:0] e_rd, e_ctl;
    logic [15:0] e_alu;
  } vec_t;

  vec_t tbl[11];
  vec_t hs[5];
  vec_t sb[$];
  vec_t idle, post;

  ex_mem_reg #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_zero(ex_zero),
    .ex_ofl(ex_ofl), .ex_sign(ex_sign), .ex_st_data(ex_st_data), .ex_rd(ex_rd), .ex_ctl(ex_ctl),
    .ex_halt(ex_halt), .mem_stall(mem_stall), .flush(flush), .ex_ready(ex_ready),
    .mem_valid(mem_valid), .mem_alu_out(mem_alu_out), .mem_st_data(mem_st_data),
    .mem_zero(mem_zero), .mem_rd(mem_rd), .mem_ctl(mem_ctl), .ofl_err(ofl_err), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t x;
    mem_stall = v.stall; flush = v.flush; ex_valid = v.valid; ex_sign = v.sign;
    ex_ofl = v.ofl; ex_halt = v.halt; ex_zero = v.zero; ex_rd = v.rd; ex_ctl = v.ctl;
    ex_alu_out = v.alu; ex_st_data = ~v.alu;
    #1;
    chk({tag, ".ex_ready"}, 16'(ex_ready), 16'(v.e_ready));
    sb.push_back(v);
    @(posedge clk); #1;
    x = sb.pop_front();
    chk({tag, ".mem_valid"}, 16'(mem_valid), 16'(x.e_valid));
    chk({tag, ".mem_alu_out"}, mem_alu_out, x.e_alu);
    chk({tag, ".mem_st_data"}, mem_st_data, ~x.e_alu);
    chk({tag, ".mem_zero"}, 16'(mem_zero), 16'(x.e_zero));
    chk({tag, ".mem_rd"}, 16'(mem_rd), 16'(x.e_rd));
    chk({tag, ".mem_ctl"}, 16'(mem_ctl), 16'(x.e_ctl));
    chk({tag, ".ofl_err"}, 16'(ofl_err), 16'(x.e_ofl));
    chk({tag, ".halted"}, 16'(halted), 16'(x.e_halted));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".mem_valid"}, 16'(mem_valid), 16'h0);
    chk({tag, ".mem_alu_out"}, mem_alu_out, 16'h0);
    chk({tag, ".mem_st_data"}, mem_st_data, 16'h0);
    chk({tag, ".mem_zero"}, 16'(mem_zero), 16'h0);
    chk({tag, ".mem_rd"}, 16'(mem_rd), 16'h0);
    chk({tag, ".mem_ctl"}, 16'(mem_ctl), 16'h0);
    chk({tag, ".ofl_err"}, 16'(ofl_err), 16'h0);
    chk({tag, ".halted"}, 16'(halted), 16'h0);
  endtask

  initial begin
    // stall flush valid sign ofl halt zero rd ctl alu | ready valid zero ofl halted rd ctl alu
    tbl[0]  = '{0,0,1,0,0,0,1,3'd5,3'b100,16'h1234, 1,1,1,0,0,3'd5,3'b100,16'h1234};
    tbl[1]  = '{1,1,1,0,0,0,0,3'd2,3'b010,16'h5555, 0,1,1,0,0,3'd5,3'b100,16'h1234};
    tbl[2]  = '{1,1,1,1,1,0,0,3'd3,3'b011,16'h6666, 0,1,1,0,0,3'd5,3'b100,16'h1234};
    tbl[3]  = '{1,0,1,0,0,0,0,3'd4,3'b001,16'h7777, 0,1,1,0,0,3'd5,3'b100,16'h1234};
    tbl[4]  = '{0,1,1,1,1,0,0,3'd6,3'b110,16'h0bad, 1,0,0,0,0,3'd6,3'b000,16'h0bad};
    tbl[5]  = '{0,0,1,0,1,0,1,3'd1,3'b001,16'h1111, 1,1,1,0,0,3'd1,3'b001,16'h1111};
    tbl[6]  = '{0,0,0,1,1,0,0,3'd7,3'b111,16'h2222, 1,0,0,0,0,3'd7,3'b000,16'h2222};
    tbl[7]  = '{0,0,1,1,1,0,1,3'd2,3'b100,16'h3333, 1,1,1,1,0,3'd2,3'b100,16'h3333};
    tbl[8]  = '{0,0,1,0,0,0,0,3'd3,3'b010,16'h4444, 1,1,0,1,0,3'd3,3'b010,16'h4444};
    tbl[9]  = '{0,1,1,0,0,1,0,3'd4,3'b100,16'h5050, 1,0,0,1,0,3'd4,3'b000,16'h5050};
    tbl[10] = '{0,0,1,0,0,0,1,3'd0,3'b001,16'h6060, 1,1,1,1,0,3'd0,3'b001,16'h6060};
    idle    = '{0,0,0,0,0,0,0,3'd0,3'b000,16'h0000, 1,0,0,1,0,3'd0,3'b000,16'h0000};
    // halt capture, two stalled DRAIN cycles, then HALTED holding
    hs[0]   = '{0,0,1,0,0,1,0,3'd3,3'b100,16'h7070, 1,1,0,1,0,3'd3,3'b100,16'h7070};
    hs[1]   = '{1,0,1,0,0,0,1,3'd1,3'b001,16'h8080, 0,1,0,1,0,3'd3,3'b100,16'h7070};
    hs[2]   = '{1,1,1,0,0,0,1,3'd2,3'b010,16'h8181, 0,1,0,1,0,3'd3,3'b100,16'h7070};
    hs[3]   = '{0,0,1,1,1,0,1,3'd6,3'b001,16'h9090, 0,0,0,1,1,3'd3,3'b100,16'h7070};
    hs[4]   = '{0,0,1,0,0,1,1,3'd7,3'b111,16'ha0a0, 0,0,0,1,1,3'd3,3'b100,16'h7070};
    post    = '{0,0,1,0,0,0,1,3'd6,3'b100,16'hbeef, 1,1,1,0,0,3'd6,3'b100,16'hbeef};

    {ex_valid, ex_zero, ex_ofl, ex_sign, ex_halt, mem_stall, flush} = '0;
    ex_alu_out = '0; ex_st_data = '0; ex_rd = '0; ex_ctl = '0;
    #1 rst_n = 0;
    #1 chk_zero("reset");
    chk("reset.ex_ready", 16'(ex_ready), 16'h1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    for (int k = 0; k < 10; k++) apply(idle, $sformatf("sticky%0d", k));
    foreach (hs[i]) apply(hs[i], $sformatf("halt%0d", i));

    #3 rst_n = 0;
    #1 chk_zero("async_rst");
    chk("async_rst.ex_ready", 16'(ex_ready), 16'h1);
    #2 rst_n = 1;
    apply(post, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameter N, default 16, datapath width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ex_valid  input  1  execute stage presents a valid instruction.
REQ-005 ex_alu_out  input  N  ALU result.
REQ-006 ex_zero  input  1  ALU zero flag.
REQ-007 ex_ofl  input  1  ALU overflow flag.
REQ-008 ex_sign  input  1  instruction uses signed arithmetic; qualifies ex_ofl.
REQ-009 ex_st_data  input  N  store data.
REQ-010 ex_rd  input  3  destination register index.
REQ-011 ex_ctl  input  3  {reg_wr, mem_wr, mem_rd}.
REQ-012 ex_halt  input  1  instruction is HALT.
REQ-013 mem_stall  input  1  memory stage cannot accept new data this cycle.
REQ-014 flush  input  1  discard the instruction being captured this cycle.
REQ-015 ex_ready  output  1  stage accepts ex_* this cycle.
REQ-016 mem_valid  output  1  registered valid.
REQ-017 mem_alu_out, mem_st_data  output  N each  registered copies.
REQ-018 mem_zero, mem_rd, mem_ctl  output  1/3/3  registered copies.
REQ-019 ofl_err  output  1  sticky signed-overflow exception.
REQ-020 halted  output  1  high in HALTED state.

Function
REQ-021 State machine SHALL have states RUN, DRAIN, HALTED; reset state RUN.
REQ-022 ex_ready SHALL equal ~mem_stall in RUN; it SHALL be 0 in DRAIN and HALTED.
REQ-023 Capture: in RUN with ex_ready=1, all mem_* SHALL load from ex_* at the clock edge (latency 1 cycle).
REQ-024 mem_valid SHALL load ex_valid & ~flush on capture.
REQ-025 Flushed or invalid capture: mem_ctl SHALL load 3'b000; the data fields SHALL still load.
REQ-026 mem_stall=1: all mem_* SHALL hold; flush SHALL be ignored.
REQ-027 When flush and mem_stall are both 1, mem_stall SHALL win and no register SHALL change.
REQ-028 ofl_err SHALL set on capture of ex_valid & ~flush & ex_sign & ex_ofl.
REQ-029 ofl_err SHALL clear only on reset.
REQ-030 Unsigned overflow (ex_sign=0) SHALL NOT set ofl_err.
REQ-031 On capture of a valid, unflushed ex_halt, the next state SHALL be DRAIN.
REQ-032 In DRAIN, registers SHALL hold while mem_stall=1.
REQ-033 In DRAIN with mem_stall=0, the state SHALL go to HALTED and mem_valid SHALL clear to 0.
REQ-034 In HALTED, all mem_* SHALL hold with mem_valid=0.
REQ-035 halted SHALL be 1 in HALTED; the only exit from HALTED SHALL be reset.
REQ-036 A flushed ex_halt SHALL NOT change state.
REQ-037 No combinational path SHALL exist from ex_* to mem_*; ex_ready SHALL depend only on mem_stall and state.

Reset
REQ-038 rst_n=0 SHALL immediately, independent of clk, force:
- mem_valid, mem_ctl, mem_zero, ofl_err, halted = 0
- mem_alu_out, mem_st_data, mem_rd = 0
- state = RUN
REQ-039 Reset asserted mid-DRAIN or in HALTED SHALL return the block to RUN with all outputs zero.
REQ-040 The first capture SHALL occur on the first rising edge after rst_n deasserts.

Verification
REQ-041 Capture: ex_valid=1, ex_alu_out=16'h1234, ex_ctl=3'b100, no stall -> next cycle mem_valid=1, mem_alu_out=16'h1234, mem_ctl=3'b100.
REQ-042 Stall: mem_stall=1 for 3 cycles while ex_* changes -> mem_* unchanged and ex_ready=0 throughout; flush asserted in the same cycles is ignored.
REQ-043 Flush: flush=1, ex_ctl=3'b110 -> mem_valid=0 and mem_ctl=000; ofl_err unchanged even with ex_sign=1, ex_ofl=1.
REQ-044 Overflow: signed capture with ex_ofl=1 -> ofl_err=1 and stays 1 after 10 further cycles; the same capture with ex_sign=0 -> ofl_err=0.
REQ-045 Halt: capture ex_halt with mem_stall high for 2 cycles -> DRAIN holds for 2 cycles; then HALTED, halted=1, mem_valid=0, ex_ready=0.
REQ-046 Async reset: drop rst_n between clock edges while in HALTED -> all outputs 0 and state RUN before the next clk edge.
